// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Uses shift-add multiply and restoring divide on operand magnitudes, then sign-corrects the result.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mcand_q, a_q, hi_q, lo_q;
  logic [1:0]       op_q;
  logic             neg_res_q, neg_rem_q, b_zero_q, done_q, dbz_q;
  logic             launch, commit;

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        state_d = RUN;
        launch  = 1'b1;
      end
      RUN: begin
        if (flush)                          state_d = IDLE;
        else if (cnt_q == CW'(WIDTH - 1))   state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        commit  = !flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes; unsigned ops never flag a sign.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = !op[0] && a[WIDTH-1];
  assign b_neg = !op[0] && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration: acc_lo holds multiplier/product-low or dividend/quotient.
  logic [WIDTH:0]   sum, rem_sh, trial;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  always_comb begin
    sum    = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, mcand_q};
    if (op_q[1]) begin
      if (!trial[WIDTH]) begin
        iter_hi = trial[WIDTH-1:0];
        iter_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = rem_sh[WIDTH-1:0];
        iter_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo_q[0]) begin
      iter_hi = sum[WIDTH:1];
      iter_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      iter_hi = {1'b0, acc_hi_q[WIDTH-1:1]};
      iter_lo = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;
  always_comb begin
    prod_s = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_zero_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
        res_lo = neg_res_q ? -acc_lo_q : acc_lo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      a_q       <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= commit;
      dbz_q  <= commit && op_q[1] && b_zero_q;
      if (launch) begin
        acc_hi_q  <= '0;
        acc_lo_q  <= a_mag;
        mcand_q   <= b_mag;
        a_q       <= a;
        op_q      <= op;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        b_zero_q  <= (b == '0);
        cnt_q     <= '0;
      end else if (state_q == RUN) begin
        acc_hi_q <= iter_hi;
        acc_lo_q <= iter_lo;
        cnt_q    <= cnt_q + 1'b1;
      end
      // MTHI/MTLO land alongside a same-edge start; the op result overwrites later.
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random ops vs an arithmetic model,
// flush, reset abort, start-while-busy, back-to-back and MTHI/MTLO corner cases.
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model straight from the arithmetic rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint          ps;
    longint unsigned pu;
    int              sx, sy;
    sx = x; sy = y; dz = 1'b0;
    case (o)
      2'd0: begin ps = longint'(sx) * longint'(sy); h = ps[63:32]; l = ps[31:0]; end
      2'd1: begin pu = {32'd0, x} * {32'd0, y}; h = pu[63:32]; l = pu[31:0]; end
      default: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; dz = 1'b1; end
        else if (o == 2'd3) begin h = x % y; l = x / y; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
        else begin h = sx % sy; l = sx / sy; end
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Returns edges until done is seen (-1 if none within max_cyc) and the outputs then.
  task automatic wait_done(input int max_cyc, output int lat, output logic [31:0] h,
                           output logic [31:0] l, output logic dz);
    lat = -1; h = '0; l = '0; dz = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; h = hi; l = lo; dz = div_by_zero; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h, required all 0", busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  ops[8]  = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [31:0] as[8]   = '{32'hFFFF_FFFF, -32'sd3, 32'h8000_0000, -32'sd7, 32'd100, 32'h8000_0000, 32'd100, 32'd0};
    logic [31:0] bs[8]   = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd5};
    logic [31:0] ehi[8]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd100, 32'd0};
    logic [31:0] elo[8]  = '{32'h1, 32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic        edz[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [31:0] h, l; logic dz;
    for (int i = 0; i < 8; i++) begin
      launch(ops[i], as[i], bs[i]);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL dir_busy[%0d]: busy=%b required 1", i, busy); end
      wait_done(40, lat, h, l, dz);
      checks++;
      if (lat !== 33 || h !== ehi[i] || l !== elo[i] || dz !== edz[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL dir[%0d]: lat=%0d hi=%h lo=%h dbz=%b busy=%b, required lat=33 hi=%h lo=%h dbz=%b busy=0",
                 i, lat, h, l, dz, busy, ehi[i], elo[i], edz[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b0) begin
        errors++; $display("FAIL dir_pulse[%0d]: done=%b dbz=%b, required 0 0", i, done, div_by_zero);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    logic [31:0] x, y, eh, el, h, l; logic [1:0] o; logic edz, dz; int lat;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 31);
      model(o, x, y, eh, el, edz);
      launch(o, x, y);
      wait_done(40, lat, h, l, dz);
      checks++;
      if (lat !== 33 || h !== eh || l !== el || dz !== edz) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dbz=%b, required lat=33 hi=%h lo=%h dbz=%b",
                 i, o, x, y, lat, h, l, dz, eh, el, edz);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] lo_before, h, l; logic dz; int lat;
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk); hi_we = 1'b0; lo_before = lo;
    checks++;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: hi=%h required 00001234", hi); end
    launch(2'd1, 32'd3, 32'd5);
    repeat (8) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1234 || lo !== lo_before) begin
      errors++;
      $display("FAIL flush: busy=%b hi=%h lo=%h, required busy=0 hi=00001234 lo=%h", busy, hi, lo, lo_before);
    end
    wait_done(40, lat, h, l, dz);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL flush_nodone: done seen after %0d edges, required none", lat); end
    // flush on the start edge cancels it; flush alone in IDLE does nothing
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1234) begin
      errors++; $display("FAIL flush_start: busy=%b hi=%h, required busy=0 hi=00001234", busy, hi);
    end
    @(posedge clk); #1 flush = 1'b0;
    wait_done(40, lat, h, l, dz);
    checks++;
    if (lat !== -1 || lo !== lo_before) begin
      errors++; $display("FAIL flush_idle: lat=%0d lo=%h, required no done lo=%h", lat, lo, lo_before);
    end
  endtask

  task automatic test_start_busy;
    int ndone = 0; logic [31:0] h = '0, l = '0;
    launch(2'd3, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done) begin if (ndone == 0) begin h = hi; l = lo; end ndone++; end
    end
    checks++;
    if (ndone !== 1 || h !== 32'd2 || l !== 32'd14) begin
      errors++; $display("FAIL start_busy: dones=%0d hi=%h lo=%h, required 1 done hi=2 lo=14", ndone, h, l);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] h, l; logic dz; int lat;
    launch(2'd0, -32'sd3, 32'd7);
    wait_done(40, lat, h, l, dz);
    checks++;
    if (lat !== 33 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL b2b_first: lat=%0d hi=%h lo=%h, required 33 ffffffff ffffffeb", lat, h, l);
    end
    launch(2'd3, 32'd1000, 32'd33);
    wait_done(40, lat, h, l, dz);
    checks++;
    if (lat !== 33 || h !== 32'd10 || l !== 32'd30) begin
      errors++; $display("FAIL b2b_second: lat=%0d hi=%h lo=%h, required 33 0000000a 0000001e", lat, h, l);
    end
  endtask

  task automatic test_mt_write;
    logic [31:0] hi_before, h, l; logic dz; int lat;
    hi_before = hi;
    @(negedge clk); start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd0; lo_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1 start = 1'b0; lo_we = 1'b0;
    checks++;
    if (lo !== 32'hABCD || busy !== 1'b1) begin
      errors++; $display("FAIL mtlo_start: lo=%h busy=%b, required 0000abcd 1", lo, busy);
    end
    @(negedge clk); hi_we = 1'b1; wdata = 32'h5555;
    @(posedge clk); #1 hi_we = 1'b0;
    checks++;
    if (hi !== hi_before) begin errors++; $display("FAIL mthi_busy: hi=%h required %h", hi, hi_before); end
    wait_done(40, lat, h, l, dz);
    checks++;
    if (lat !== 32 || h !== 32'd100 || l !== 32'hFFFF_FFFF || dz !== 1'b1) begin
      errors++; $display("FAIL divu_zero: lat=%0d hi=%h lo=%h dbz=%b, required 32 00000064 ffffffff 1", lat, h, l, dz);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] h, l; logic dz; int lat;
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    launch(2'd2, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
    end
    @(negedge clk) reset = 1'b0;
    wait_done(40, lat, h, l, dz);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL reset_nodone: done after %0d edges, required none", lat); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_start_busy;
    test_back_to_back;
    test_mt_write;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
